// File: rtl/shreg_pkg.sv
// -----------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the LED shift-register sequencer and its prescaler.
//   state_e   : sequencer state encoding, also driven out on state_o
//   SPEED_MAX : largest speed code; the prescaler period is TICK_DIV << speed
//   LED_W     : width of the LED shift register (and of the pattern)
// -----------------------------------------------------------------------------
package shreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  localparam int SPEED_MAX = 3;
  localparam int LED_W     = 8;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Shift-rate prescaler. Counts 0 .. (TICK_DIV << speed_i) - 1 while enabled
// and emits a one-cycle tick on the terminal count. Holds at 0 while disabled
// or cleared, and restarts from 0 whenever the speed code changes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en_i      : count enable (sequencer is running)
//   clr_i     : synchronous clear (sequencer is leaving RUN)
//   speed_i   : period select, period = TICK_DIV << speed_i
//   tick_o    : one-cycle pulse on the terminal count
// -----------------------------------------------------------------------------
module tick_gen
  import shreg_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [1:0] speed_i,
  output logic       tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV << SPEED_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_cnt;
  logic [1:0]       speed_q;
  logic             speed_chg;

  assign term_cnt  = CNT_W'((TICK_DIV << speed_i) - 1);
  assign speed_chg = (speed_i != speed_q);

  // A speed change in the very cycle the old period expires restarts the
  // count instead of firing, so the new period always starts clean.
  assign tick_o = en_i && !clr_i && !speed_chg && (cnt_q == term_cnt);

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d (no latch).
    cnt_d = cnt_q + 1'b1;
    if (!en_i || clr_i || speed_chg || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      speed_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      cnt_q   <= cnt_d;
      speed_q <= speed_i;
    end
  end

endmodule

// File: rtl/shreg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shreg_seq_ctrl
// Sequencer for the LED shift register. Streams a programmable pattern MSB
// first into the register's serial input, one bit per shift tick, under
// start/stop/pause/step control, and counts completed pattern passes.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (shared with SR)
//   start/stop/pause/step : one-cycle command pulses, priority stop > start >
//                     pause > step; commands invalid in a state are ignored
//   load, pattern   : capture pattern (accepted in IDLE/PAUSE only)
//   speed           : tick period = TICK_DIV << speed
//   sr_status       : shift register reports all-zero
//   sr_en, sr_sin   : one-cycle shift strobe and its serial bit
//   sr_clr          : one-cycle clear pulse on stop
//   busy            : high in RUN
//   state_o         : current state (IDLE=0, RUN=1, PAUSE=2, STEP=3)
//   frame_cnt       : completed pattern passes, wraps at 255
//   load_err        : one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module shreg_seq_ctrl
  import shreg_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int PAT_W    = LED_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [1:0]       speed,
  input  logic             sr_status,
  output logic             sr_en,
  output logic             sr_sin,
  output logic             sr_clr,
  output logic             busy,
  output logic [1:0]       state_o,
  output logic [7:0]       frame_cnt,
  output logic             load_err
);

  localparam int                PTR_W   = $clog2(PAT_W);
  localparam logic [PTR_W-1:0]  PTR_TOP = PTR_W'(PAT_W - 1);

  state_e           state_q;
  logic [PAT_W-1:0] pattern_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_next;
  logic             ptr_wrap;
  logic [7:0]       frame_q;
  logic             sr_en_q, sr_sin_q, sr_clr_q, busy_q, load_err_q;
  logic             tick;
  logic             leave_run;

  // The pointer advances when a strobe is issued, so the bit for the next
  // strobe is always pattern_q[ptr_q] regardless of when it is requested.
  assign ptr_wrap = (ptr_q == '0);
  assign ptr_next = ptr_wrap ? PTR_TOP : ptr_q - 1'b1;

  assign leave_run = (state_q == ST_RUN) && (stop || pause);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == ST_RUN),
    .clr_i   (leave_run),
    .speed_i (speed),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      // NOTE: the pattern register is a plain flop bank, so it is reset too.
      pattern_q  <= '0;
      ptr_q      <= PTR_TOP;
      frame_q    <= '0;
      sr_en_q    <= 1'b0;
      sr_sin_q   <= 1'b0;
      sr_clr_q   <= 1'b0;
      busy_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sr_en_q    <= 1'b0;
      sr_sin_q   <= 1'b0;
      sr_clr_q   <= 1'b0;
      load_err_q <= 1'b0;

      if (stop && state_q != ST_IDLE) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        sr_clr_q <= 1'b1;
        ptr_q    <= PTR_TOP;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSE;
              busy_q  <= 1'b0;
            end else if (tick) begin
              // Nothing left to shift out and nothing loaded: stop quietly,
              // the register is already clear.
              if (pattern_q == '0 && sr_status) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                ptr_q   <= PTR_TOP;
              end else begin
                sr_en_q  <= 1'b1;
                sr_sin_q <= pattern_q[ptr_q];
                ptr_q    <= ptr_next;
                if (ptr_wrap) frame_q <= frame_q + 8'd1;
              end
            end
          end
          ST_PAUSE: begin
            if (start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else if (step) begin
              state_q  <= ST_STEP;
              sr_en_q  <= 1'b1;
              sr_sin_q <= pattern_q[ptr_q];
              ptr_q    <= ptr_next;
              if (ptr_wrap) frame_q <= frame_q + 8'd1;
            end
          end
          ST_STEP: begin
            state_q <= ST_PAUSE;
          end
        endcase
      end

      // Load sits after the state logic so an accepted load owns the pointer.
      if (load) begin
        if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
          pattern_q <= pattern;
          ptr_q     <= PTR_TOP;
        end else begin
          load_err_q <= 1'b1;
        end
      end
    end
  end

  assign sr_en     = sr_en_q;
  assign sr_sin    = sr_sin_q;
  assign sr_clr    = sr_clr_q;
  assign busy      = busy_q;
  assign state_o   = state_q;
  assign frame_cnt = frame_q;
  assign load_err  = load_err_q;

endmodule
